dac_sample_sequencer: RTL
=========================

Name: dac_sample_sequencer

Overview:
- Paces samples from an upstream audio source into the unsigned `d` input of a sigma-delta DAC (the hybrid 2nd-order filtered DAC or a sibling).
- Samples are accepted over a valid/ready handshake into a one-entry buffer and issued on a programmable sample-rate tick.
- Start and stop are soft: the DAC input ramps between midscale and signal, so enable/disable does not pop.
- Underruns hold the last value and are counted.

Parameters:
signalwidth, 16, sample width (unsigned, offset binary; midscale = 1<<(signalwidth-1))
divbits, 16, width of sample-rate divider
rampstep, 16'h1000, maximum change of dac_d per tick while ramping (width signalwidth)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, synchronous, active-low
enable  in  1  level; 1 = play, 0 = ramp to midscale and stop
divider  in  divbits  tick period minus 1 (0 = tick every clk)
s_data  in  signalwidth  upstream sample, unsigned
s_valid  in  1  s_data valid
s_ready  out  1  block accepts s_data this cycle
dac_d  out  signalwidth  registered value driven to DAC d
state  out  2  0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
clr_underrun  in  1  clears underrun_count
underrun_count  out  8  saturating count of underrun ticks

Behaviour:
- Reset is synchronous and active-low (reset_n low at a clk rising edge). It sets:
  - dac_d = midscale, state = IDLE
  - tick counter = 0, buf_full = 0, underrun_count = 0
  - s_ready therefore reads 0.
- Tick generator (free-running in all states):
  - If counter >= divider: tick = 1 and counter <= 0.
  - Otherwise counter <= counter + 1.
  - Comparison is >=, so a reduced divider takes effect on the next cycle.
  - divider = 0 gives a tick every cycle.
- Buffer and handshake:
  - s_ready = !buf_full in RAMP_UP and RUN; s_ready = 0 in IDLE and RAMP_DOWN.
  - Accept when s_valid && s_ready: buf <= s_data, buf_full <= 1.
  - A consume clears buf_full; a sample accepted in a cycle is not consumable before the following cycle.
  - Entering IDLE forces buf_full <= 0 (buffered sample discarded).
- Ramp step (RAMP_UP toward buf, RAMP_DOWN toward midscale), on a tick only:
  - diff = target - dac_d, computed in signalwidth+1 signed bits.
  - If |diff| <= rampstep: dac_d <= target. Otherwise dac_d <= dac_d ± rampstep.
  - No wrap is possible.
- IDLE:
  - dac_d holds midscale.
  - If enable = 1, go to RAMP_UP next cycle.
- RAMP_UP:
  - If enable = 0, go to RAMP_DOWN; this takes priority and no step or consume happens that cycle.
  - On a tick with buf_full = 1: apply a ramp step toward buf. If that step reaches buf, consume the buffer and set state <= RUN in the same cycle.
  - On a tick with buf_full = 0: hold; this is not counted as an underrun.
- RUN:
  - If enable = 0, go to RAMP_DOWN; the check is level-based and not tick-aligned, and the buffered sample is not consumed.
  - On a tick with buf_full = 1: dac_d <= buf and consume.
  - On a tick with buf_full = 0: dac_d holds and underrun_count increments, saturating at 255.
- RAMP_DOWN:
  - On a tick, apply a ramp step toward midscale. If dac_d reaches midscale, state <= IDLE.
  - If enable = 1 (and dac_d is not at midscale this cycle), go to RAMP_UP, ramping from the current dac_d.
- Simultaneous events:
  - clr_underrun wins over an increment in the same cycle (result 0).
  - reset_n wins over everything.
- All outputs are registered except s_ready, which is a combinational decode of state and buf_full.
- Latency:
  - A sample appears on dac_d on the first tick at least 1 cycle after acceptance.
  - dac_d changes only on ticks.

Test Plan:
1. Reset, signalwidth = 16, divider = 3, rampstep = 16'h1000: hold reset_n low for 2 clks, release -> dac_d = 16'h8000, state = 0, s_ready = 0, underrun_count = 0, tick every 4th clk.
2. Start ramp: enable = 1, offer 16'hA000 -> s_ready = 1 in RAMP_UP, sample accepted; dac_d = 16'h9000 on the first tick, 16'hA000 on the second tick, with state = 2 in that same cycle.
3. Streaming in RUN: s_valid held high with 16'h1111, 16'h2222, 16'h3333 -> one acceptance per tick period, dac_d steps through those values exactly every 4 clks, underrun_count stays 0.
4. Underrun:
   - Drop s_valid for 3 ticks -> dac_d holds its last value, underrun_count = 3.
   - Continue for 300 ticks -> underrun_count = 255.
   - Assert clr_underrun on a tick cycle -> underrun_count = 0.
5. Stop and restart:
   - From RUN at dac_d = 16'hA000, enable = 0 with a sample buffered -> state = 3, dac_d = 16'h9000 then 16'h8000, then state = 0 with buffer discarded and s_ready = 0.
   - Repeat, but set enable = 1 when dac_d = 16'h9000 -> state = 1 and the ramp continues from 16'h9000.
6. Divider and reset:
   - divider = 100, counter at 50, change divider to 2 -> tick on the next clk, then every 3 clks.
   - Pulse reset_n low mid RAMP_DOWN -> dac_d = 16'h8000 and state = 0 after that clk edge.

Source files
------------

// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: paces upstream samples into a sigma-delta DAC input.
// Samples arrive over a valid/ready handshake into a one-entry buffer and are
// issued on a programmable sample-rate tick. Start/stop ramp between midscale
// and signal to avoid pops. Underrun ticks in RUN are counted (saturating).
//
// Ports:
//   clk, reset_n    clock, synchronous active-low reset
//   enable          1 = play, 0 = ramp to midscale and stop
//   divider         tick period minus 1
//   s_data/s_valid  upstream sample and its valid
//   s_ready         combinational: buffer can accept this cycle
//   dac_d           registered value driven to the DAC
//   state           0 IDLE, 1 RAMP_UP, 2 RUN, 3 RAMP_DOWN
//   clr_underrun    clears underrun_count (wins over an increment)
//   underrun_count  saturating count of underrun ticks
module dac_sample_sequencer #(
  parameter int unsigned             signalwidth = 16,
  parameter int unsigned             divbits     = 16,
  parameter logic [signalwidth-1:0]  rampstep    = 16'h1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [divbits-1:0]     divider,
  input  logic [signalwidth-1:0] s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [signalwidth-1:0] dac_d,
  output logic [1:0]             state,
  input  logic                   clr_underrun,
  output logic [7:0]             underrun_count
);

  localparam logic [signalwidth-1:0] MIDSCALE = {1'b1, {(signalwidth-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                   state_q, state_nxt;
  logic [signalwidth-1:0]   dac_q, dac_nxt;
  logic [signalwidth-1:0]   buf_q;
  logic                     buf_full_q;
  logic [divbits-1:0]       cnt_q;
  logic [7:0]               und_q;
  logic                     tick_c;
  logic                     accept_c;
  logic                     consume_c;
  logic                     underrun_c;
  logic [signalwidth-1:0]   step_up_c;
  logic [signalwidth-1:0]   step_down_c;

  // One ramp step from cur toward tgt, clamped to land exactly on tgt.
  function automatic logic [signalwidth-1:0] ramp_to(
    input logic [signalwidth-1:0] cur,
    input logic [signalwidth-1:0] tgt
  );
    logic signed [signalwidth:0] diff;
    logic        [signalwidth:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag  = diff[signalwidth] ? $unsigned(-diff) : $unsigned(diff);
    if (mag <= {1'b0, rampstep}) begin
      ramp_to = tgt;
    end else if (diff[signalwidth]) begin
      ramp_to = cur - rampstep;
    end else begin
      ramp_to = cur + rampstep;
    end
  endfunction

  // Free-running tick; >= so a reduced divider takes effect immediately.
  assign tick_c      = (cnt_q >= divider);
  assign s_ready     = !buf_full_q && ((state_q == RAMP_UP) || (state_q == RUN));
  assign accept_c    = s_valid && s_ready;
  assign step_up_c   = ramp_to(dac_q, buf_q);
  assign step_down_c = ramp_to(dac_q, MIDSCALE);

  assign dac_d          = dac_q;
  assign state          = state_q;
  assign underrun_count = und_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state, DAC value and buffer/underrun events.
  always_comb begin
    state_nxt  = state_q;
    dac_nxt    = dac_q;
    consume_c  = 1'b0;
    underrun_c = 1'b0;
    case (state_q)
      IDLE: begin
        dac_nxt = MIDSCALE;
        if (enable) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
        end else if (tick_c && buf_full_q) begin
          dac_nxt = step_up_c;
          if (step_up_c == buf_q) begin
            consume_c = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = RAMP_DOWN;
        end else if (tick_c) begin
          if (buf_full_q) begin
            dac_nxt   = buf_q;
            consume_c = 1'b1;
          end else begin
            underrun_c = 1'b1;
          end
        end
      end
      RAMP_DOWN: begin
        // Re-enable resumes the ramp from wherever dac_d currently is.
        if (enable && (dac_q != MIDSCALE)) begin
          state_nxt = RAMP_UP;
        end else if (tick_c) begin
          dac_nxt = step_down_c;
          if (step_down_c == MIDSCALE) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: tick counter, DAC register, sample buffer, underrun counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      dac_q      <= MIDSCALE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      und_q      <= '0;
    end else begin
      cnt_q <= tick_c ? '0 : cnt_q + divbits'(1);
      dac_q <= dac_nxt;
      // accept needs an empty buffer and consume a full one, so never both.
      if (state_nxt == IDLE) begin
        buf_full_q <= 1'b0;
      end else if (accept_c) begin
        buf_full_q <= 1'b1;
      end else if (consume_c) begin
        buf_full_q <= 1'b0;
      end
      if (accept_c) buf_q <= s_data;
      if (clr_underrun) begin
        und_q <= '0;
      end else if (underrun_c && (und_q != 8'hFF)) begin
        und_q <= und_q + 8'd1;
      end
    end
  end

endmodule
